formula_2_seq: RTL and testbench

FORMULA_2_SEQ -- requirements
Module: formula_2_seq

---
 rtl/formula_2_seq.sv | 200 ++++++++++++++++++++
 tb/tb_formula_2_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/formula_2_seq.sv
`default_nettype none
// formula_2_seq: res = isqrt(a + isqrt(b + isqrt(c))) with one pipelined isqrt reused over three passes.
// Build option FORMULA_2_SEQ_RES_RDY_EN adds a res_rdy input that holds the result in DONE until taken.

module isqrt #(
  parameter int n_pipe_stages = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  localparam int NS = n_pipe_stages;

  typedef struct packed {
    logic [31:0] xs;
    logic [19:0] rem;
    logic [15:0] root;
  } st_t;

  // Restoring digit-by-digit square root; each stage runs its share of the 16 result bits.
  function automatic st_t steps(input st_t si, input int lo, input int hi);
    st_t         s;
    logic [19:0] trial;
    s = si;
    for (int i = 0; i < 16; i++) begin
      if (i >= lo && i < hi) begin
        s.rem = {s.rem[17:0], s.xs[31:30]};
        s.xs  = {s.xs[29:0], 2'b00};
        trial = {2'b00, s.root, 2'b01};
        if (s.rem >= trial) begin
          s.rem  = s.rem - trial;
          s.root = {s.root[14:0], 1'b1};
        end else begin
          s.root = {s.root[14:0], 1'b0};
        end
      end
    end
    return s;
  endfunction

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam int LO = (k * 16) / NS;
    localparam int HI = ((k + 1) * 16) / NS;
    st_t  s_in;
    logic v_in;
    st_t  s_q;
    logic v_q;

    if (k == 0) begin : g_head
      assign s_in = {x, 20'd0, 16'd0};
      assign v_in = x_vld;
    end else begin : g_tail
      assign s_in = g_stage[k-1].s_q;
      assign v_in = g_stage[k-1].v_q;
    end

    // Data only advances with a valid token so idle cycles do not toggle the datapath.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= '0;
        v_q <= 1'b0;
      end else begin
        v_q <= v_in;
        if (v_in) s_q <= steps(s_in, LO, HI);
      end
    end
  end

  logic unused_tail;
  assign unused_tail = ^{g_stage[NS-1].s_q.xs, g_stage[NS-1].s_q.rem};

  assign y     = g_stage[NS-1].s_q.root;
  assign y_vld = g_stage[NS-1].v_q;

endmodule

module formula_2_seq #(
  parameter int ISQRT_STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  output logic        arg_rdy,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
`ifdef FORMULA_2_SEQ_RES_RDY_EN
  input  logic        res_rdy,
`endif
  output logic        res_vld,
  output logic [31:0] res
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PASS_C = 3'd1,
    PASS_B = 3'd2,
    PASS_A = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] c_q;
  logic        issue_c;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;
  logic [31:0] y_ext;
  logic        done_exit;

`ifdef FORMULA_2_SEQ_RES_RDY_EN
  assign done_exit = res_rdy;
`else
  assign done_exit = 1'b1;
`endif

  assign y_ext = {16'd0, y};

  // Each pass result feeds the next pass in the same cycle it appears.
  always_comb begin
    x_vld = 1'b0;
    x     = '0;
    if (issue_c) begin
      x_vld = 1'b1;
      x     = c_q;
    end else if (y_vld && state == PASS_C) begin
      x_vld = 1'b1;
      x     = b_q + y_ext;
    end else if (y_vld && state == PASS_B) begin
      x_vld = 1'b1;
      x     = a_q + y_ext;
    end
  end

  isqrt #(
    .n_pipe_stages(ISQRT_STAGES)
  ) u_isqrt (
    .clk  (clk),
    .rst  (~rst),
    .x_vld(x_vld),
    .x    (x),
    .y_vld(y_vld),
    .y    (y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      arg_rdy <= 1'b0;
      res_vld <= 1'b0;
      res     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      issue_c <= 1'b0;
    end else begin
      issue_c <= 1'b0;
      case (state)
        IDLE: begin
          if (arg_vld && arg_rdy) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= c;
            arg_rdy <= 1'b0;
            issue_c <= 1'b1;
            state   <= PASS_C;
          end else begin
            arg_rdy <= 1'b1;
          end
        end
        PASS_C: if (y_vld) state <= PASS_B;
        PASS_B: if (y_vld) state <= PASS_A;
        PASS_A: begin
          if (y_vld) begin
            res     <= y_ext;
            res_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (done_exit) begin
            res_vld <= 1'b0;
            arg_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_formula_2_seq.sv
`default_nettype none
// tb_formula_2_seq: randomized and directed checks of formula_2_seq against an arithmetic reference.
module tb_formula_2_seq;

  localparam int N   = 4;
  localparam int LAT = 3 * N + 2;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        arg_vld = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] c = '0;
  logic        arg_rdy;
  logic        res_vld;
  logic [31:0] res;
`ifdef FORMULA_2_SEQ_RES_RDY_EN
  logic        res_rdy = 1'b1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  formula_2_seq #(
    .ISQRT_STAGES(N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arg_vld(arg_vld),
    .arg_rdy(arg_rdy),
    .a      (a),
    .b      (b),
    .c      (c),
`ifdef FORMULA_2_SEQ_RES_RDY_EN
    .res_rdy(res_rdy),
`endif
    .res_vld(res_vld),
    .res    (res)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_isqrt(input logic [31:0] v);
    longint vv;
    longint r;
    vv = {32'd0, v};
    r  = longint'($sqrt(real'(v)));
    while (r * r > vv) r--;
    while ((r + 1) * (r + 1) <= vv) r++;
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_formula(input logic [31:0] ta, input logic [31:0] tb_,
                                              input logic [31:0] tc);
    logic [31:0] t;
    t = tb_ + ref_isqrt(tc);
    t = ta + ref_isqrt(t);
    return ref_isqrt(t);
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return $urandom_range(0, 1000);
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_rdy();
    int k;
    k = 0;
    while (!arg_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!arg_rdy) check("rdy_timeout", 32'(arg_rdy), 32'd1);
  endtask

  // Cycle 0 is the cycle arg_vld is presented with arg_rdy high; result due in cycle LAT.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] tc,
                       input bit noise, input bit hold_vld);
    logic [31:0] exp;
    exp = ref_formula(ta, tb_, tc);
    wait_rdy();
    arg_vld = 1'b1;
    a = ta;
    b = tb_;
    c = tc;
    for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
      @(negedge clk);
      check("res_vld", 32'(res_vld), 32'(cyc == LAT));
      if (cyc == LAT) check("res", res, exp);
      check("arg_rdy", 32'(arg_rdy), 32'(cyc == LAT + 1));
      if (!dut.x_vld) check("x_idle", dut.x, 32'd0);
      if (cyc <= LAT) begin
        if (hold_vld) arg_vld = 1'b1;
        else arg_vld = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
          a = $urandom;
          b = $urandom;
          c = $urandom;
        end
      end else if (!hold_vld) begin
        arg_vld = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_arg_rdy", 32'(arg_rdy), 32'd0);
    check("rst_res_vld", 32'(res_vld), 32'd0);
    check("rst_res", res, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 32'(arg_rdy), 32'd1);

    do_op(32'd5, 32'd12, 32'd16, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) do_op(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    arg_vld = 1'b0;

    // Reset pulse while the second pass is in flight.
    wait_rdy();
    arg_vld = 1'b1;
    a = 32'd100;
    b = 32'd200;
    c = 32'd300;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      arg_vld = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("mid_rst_arg_rdy", 32'(arg_rdy), 32'd0);
    check("mid_rst_res", res, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rdy_after_mid_rst", 32'(arg_rdy), 32'd1);
    for (int cyc = 0; cyc < LAT + 4; cyc++) begin
      @(negedge clk);
      check("no_res_after_rst", 32'(res_vld), 32'd0);
      check("no_stale_y", 32'(dut.y_vld), 32'd0);
    end
    do_op(32'd5, 32'd12, 32'd16, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) do_op(rnd_word(), rnd_word(), rnd_word(), 1'b1, 1'b0);

`ifdef FORMULA_2_SEQ_RES_RDY_EN
    begin
      logic [31:0] exp;
      exp = ref_formula(32'd77, 32'd1234, 32'd99999);
      wait_rdy();
      res_rdy = 1'b0;
      arg_vld = 1'b1;
      a = 32'd77;
      b = 32'd1234;
      c = 32'd99999;
      for (int cyc = 1; cyc <= LAT; cyc++) begin
        @(negedge clk);
        arg_vld = 1'b0;
      end
      check("bp_res_vld", 32'(res_vld), 32'd1);
      check("bp_res", res, exp);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("bp_hold_vld", 32'(res_vld), 32'd1);
        check("bp_hold_res", res, exp);
        check("bp_hold_rdy", 32'(arg_rdy), 32'd0);
      end
      res_rdy = 1'b1;
      @(negedge clk);
      check("bp_release_vld", 32'(res_vld), 32'd0);
      check("bp_release_rdy", 32'(arg_rdy), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
